// File: rtl/key_tone_select_pkg.sv
// Shared defaults, FSM encoding and key-index width for the key-to-speaker tone selector.
// No datapath here; no backpressure.
package key_tone_select_pkg;

    localparam int NUM_KEYS_DEF      = 12;
    localparam int DB_COUNT_DEF      = 500000;
    localparam int SUSTAIN_COUNT_DEF = 12500000;
    localparam int KEY_IDX_W         = $clog2(NUM_KEYS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser then a run-length debouncer; stable bit moves after DB_COUNT disagreeing cycles.
// Latency 2 + DB_COUNT cycles from a clean edge on key_raw; no backpressure.
module key_debounce
    import key_tone_select_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_stable
);

    localparam int DW = $clog2(DB_COUNT + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [DW-1:0] r_cnt;

    // The counter is cleared when the stable bit moves, so it tops out at DB_COUNT-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt >= DW'(DB_COUNT - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign key_stable = r_stable;

endmodule

// File: rtl/key_tone_select.sv
// Debounces keys, picks the lowest pressed key and drives its tone to spk (1-cycle registered lag),
// sustaining after release and switching notes only on falling edges; no backpressure.
module key_tone_select
    import key_tone_select_pkg::*;
#(
    parameter int NUM_KEYS      = NUM_KEYS_DEF,
    parameter int DB_COUNT      = DB_COUNT_DEF,
    parameter int SUSTAIN_COUNT = SUSTAIN_COUNT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         keys_raw,
    input  logic [NUM_KEYS-1:0]         tones,
    output logic                        spk,
    output logic [$clog2(NUM_KEYS)-1:0] key_idx,
    output logic                        playing
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int SW = $clog2(SUSTAIN_COUNT + 1);

    logic [NUM_KEYS-1:0] w_stable;
    logic                w_any;
    logic [KW-1:0]       w_cand;
    logic                w_tone;
    logic                w_fall;
    logic                w_switch;

    state_t        r_state, w_state_nxt;
    logic [KW-1:0] r_sel,   w_sel_nxt;
    logic [SW-1:0] r_sus,   w_sus_nxt;
    logic          r_spk,   w_spk_nxt;
    logic          r_prev;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DB_COUNT (DB_COUNT)
        ) u_db (
            .clk        (clk),
            .reset      (reset),
            .key_raw    (keys_raw[g]),
            .key_stable (w_stable[g])
        );
    end

    always_comb begin
        w_cand = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_stable[i]) w_cand = KW'(i);
        end
    end

    assign w_any    = |w_stable;
    assign w_tone   = tones[r_sel];
    assign w_fall   = r_prev & ~w_tone;
    assign w_switch = w_any && (w_cand != r_sel) && w_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_sus   <= '0;
            r_spk   <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_sus   <= w_sus_nxt;
            r_spk   <= w_spk_nxt;
            r_prev  <= w_tone;
        end
    end

    // Release takes precedence over a pending note switch; a re-press beats sustain expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_sus_nxt   = r_sus;
        w_spk_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_PLAY;
                    w_sel_nxt   = w_cand;
                end
            end
            ST_PLAY: begin
                w_spk_nxt = w_tone;
                if (!w_any) begin
                    w_sus_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end else if (w_switch) begin
                    w_sel_nxt = w_cand;
                end
            end
            ST_RELEASE: begin
                w_spk_nxt = w_tone;
                if (w_any) begin
                    w_state_nxt = ST_PLAY;
                    w_sus_nxt   = '0;
                    if (w_switch) w_sel_nxt = w_cand;
                end else if (r_sus == SW'(SUSTAIN_COUNT - 1)) begin
                    // Wait out the high phase so the last cycle is never clipped.
                    if (!w_tone) begin
                        w_state_nxt = ST_IDLE;
                        w_spk_nxt   = 1'b0;
                    end
                end else begin
                    w_sus_nxt = r_sus + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign spk     = r_spk;
    assign key_idx = r_sel;
    assign playing = (r_state == ST_PLAY) || (r_state == ST_RELEASE);

endmodule

// File: doc/key_tone_select.md
Name: key_tone_select

Overview:
- Sits directly downstream of the per-note tone dividers (one square-wave generator per piano key, 50 MHz clk).
- Debounces the raw key buttons, picks one active key, and routes that key's tone to the single speaker pin.
- Adds a short sustain after the key is released, and switches notes only on tone falling edges.

Parameters:
- NUM_KEYS, 12, number of keys and tone inputs (one octave).
- DB_COUNT, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz).
- SUSTAIN_COUNT, 12500000, cycles the last note keeps sounding after release (250 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- keys_raw  in  NUM_KEYS  raw push-buttons, asynchronous, 1 = pressed.
- tones  in  NUM_KEYS  square waves from the note generators; registered in the clk domain.
- spk  out  1  speaker drive.
- key_idx  out  $clog2(NUM_KEYS)  index of the sounding key.
- playing  out  1  high while in PLAY or RELEASE.

Behaviour:
- Reset (reset=0, async): all synchronisers, debounce counters, stable key states, sustain counter, sel, spk, key_idx and playing go to 0; FSM goes to IDLE. This applies mid-note as well: spk drops the same cycle.
- Sync: each keys_raw bit passes through a 2-FF synchroniser. tones are not synchronised.
- Debounce (per key):
  - Stable state changes only after the synchronised input differs from it for DB_COUNT consecutive cycles.
  - Any cycle of agreement clears the counter.
  - The counter saturates; it never wraps.
- Priority: the candidate is the lowest-index key whose stable state is pressed. any_pressed is the OR of the stable states.
- prev_tone: a register holding tones[sel] from the previous cycle. A falling edge is prev_tone=1 and tones[sel]=0.
- FSM IDLE:
  - spk=0, playing=0.
  - any_pressed → load sel=candidate, go to PLAY.
- FSM PLAY:
  - spk <= tones[sel], so spk lags tones[sel] by 1 cycle.
  - If candidate≠sel, sel updates to candidate only on a falling edge; spk follows the new tone from the next cycle.
  - Release of all keys (any_pressed=0) → clear the sustain counter, go to RELEASE.
- FSM RELEASE:
  - Keeps driving tones[sel]; the sustain counter increments each cycle.
  - Any key pressed → return to PLAY and clear the counter. The sel change follows the falling-edge rule; the same key continues without interruption.
  - Counter reaches SUSTAIN_COUNT-1 → counter holds and waits for tones[sel]=0, then goes to IDLE with spk=0. This avoids truncating a high phase.
- Simultaneous events:
  - New key press and sustain expiry in the same cycle: press wins (PLAY).
  - Candidate change and release in the same cycle: release wins, sel unchanged.
- key_idx mirrors sel. It is held after IDLE is entered and is valid only while playing=1.
- Widths:
  - Debounce counters are $clog2(DB_COUNT+1) bits.
  - The sustain counter is $clog2(SUSTAIN_COUNT+1) bits.
  - All comparisons are unsigned.

Decomposition:
- Shared package:
  - NUM_KEYS default.
  - State encoding IDLE=2'd0, PLAY=2'd1, RELEASE=2'd2; unused code 2'd3 recovers to IDLE.
  - Key index width constant.
- One natural sub-module, key_debounce: the 2-FF synchroniser plus counter plus stable bit for a single key, instantiated NUM_KEYS times via generate.
- The top level holds the priority encoder, the FSM, the sustain counter and the output register.

Test Plan (DB_COUNT=4, SUSTAIN_COUNT=20, each tones[i] a square wave with half-period 3+i cycles):
- Reset behaviour: reset=0 with keys_raw=12'hFFF → spk=0, playing=0, key_idx=0 throughout. Release reset; spk follows tones[0] once the sync and debounce latency has elapsed.
- Debounce: toggle keys_raw[5] with 3-cycle pulses → stays IDLE, spk=0. Hold it 10 cycles → PLAY, key_idx=5, spk equals tones[5] delayed 1 cycle.
- Priority and switch: hold key 7, then add key 2 → key_idx remains 7 until tones[7] falls, then becomes 2. No spk pulse is shorter than one half-period.
- Sustain: release all keys during PLAY → spk keeps toggling for 20 cycles, then goes 0 at the first tones[sel]=0 cycle. playing falls on the same cycle.
- Re-press in RELEASE: press key 4 at sustain count 10 → returns to PLAY, no IDLE gap. Counter restarts from 0 on the next release.
- Mid-note reset: assert reset while spk=1 → spk=0 and playing=0 immediately (asynchronously). After deassertion, a still-held key is accepted again only after the full sync and debounce delay.
